// File: rtl/fifo_addr_generator.sv
// fifo_addr_generator
//   Circular address / extended pointer generator for a power-of-two FIFO.
//   One instance drives the write side and one drives the read side.
//   The address advances on every cycle with inc high and wraps modulo
//   2**ADDR_WIDTH. A lap bit toggles on each wrap, so ptr = {lap, addr}
//   lets the FIFO derive status directly:
//     - empty when the read and write pointers are equal;
//     - full when the pointers differ only in the MSB.
//   Optional macro FIFO_ADDR_GRAY_EN: when defined, ptr_gray is a registered
//   Gray-coded copy of ptr for clock-domain crossing. When undefined, ptr_gray
//   is tied to 0 and no Gray registers exist.
//   Reset is synchronous and active-high. Registers also carry a power-up
//   value of 0, so formal runs without reset start from a defined state.
module fifo_addr_generator #(
  parameter int ADDR_WIDTH = 4            // legal range 1..16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] addr_next,
  output logic                  wrap,
  output logic                  lap,
  output logic [ADDR_WIDTH:0]   ptr,
  output logic [ADDR_WIDTH:0]   ptr_gray
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  logic [ADDR_WIDTH-1:0] addr_q = '0;
  logic                  lap_q  = 1'b0;
  logic                  lap_next;
  logic [ADDR_WIDTH:0]   ptr_next;

  // Lookahead: the pointer value this edge will load when not in reset.
  // NOTE: every always_comb output is fully assigned on every pass, so no latch is inferred.
  always_comb begin
    addr_next = addr_q + ADDR_WIDTH'(inc);
    wrap      = inc && (addr_q == ADDR_MAX);
    lap_next  = lap_q ^ wrap;
    ptr_next  = {lap_next, addr_next};
  end

  // Pointer state: clear on reset, otherwise load the lookahead value
  // (which equals the current value when inc is low).
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      lap_q  <= 1'b0;
    end else begin
      addr_q <= addr_next;
      lap_q  <= lap_next;
    end
  end

  assign addr = addr_q;
  assign lap  = lap_q;
  assign ptr  = {lap_q, addr_q};

`ifdef FIFO_ADDR_GRAY_EN
  logic [ADDR_WIDTH:0] gray_q = '0;

  // Gray register loaded from the next pointer, so it stays cycle-aligned
  // with ptr and only one bit changes per increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= ptr_next ^ (ptr_next >> 1);
    end
  end

  assign ptr_gray = gray_q;
`else
  assign ptr_gray = '0;
`endif

endmodule

// File: tb/tb_fifo_addr_generator.sv
// tb_fifo_addr_generator
//   Self-checking bench for fifo_addr_generator (ADDR_WIDTH=4).
//   The reference model is a single integer count of increments modulo
//   2**(ADDR_WIDTH+1); addr, lap, ptr and Gray values are derived from it
//   arithmetically. Directed sequences cover reset, wrap, full lap, hold
//   and reset mid-stream, followed by randomized rst/inc traffic.
module tb_fifo_addr_generator;

  localparam int W     = 4;
  localparam int DEPTH = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         inc;
  logic [W-1:0] addr;
  logic [W-1:0] addr_next;
  logic         wrap;
  logic         lap;
  logic [W:0]   ptr;
  logic [W:0]   ptr_gray;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;   // increments since reset, modulo 2*DEPTH

  fifo_addr_generator #(.ADDR_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .addr      (addr),
    .addr_next (addr_next),
    .wrap      (wrap),
    .lap       (lap),
    .ptr       (ptr),
    .ptr_gray  (ptr_gray)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_gray(input int p);
`ifdef FIFO_ADDR_GRAY_EN
    return p ^ (p >> 1);
`else
    return 0 & p;
`endif
  endfunction

  // One clock cycle: drive inputs mid-cycle, check the lookahead outputs,
  // let the edge happen, advance the model, then check registered outputs.
  task automatic step(input logic rst_v, input logic inc_v);
    int cur_addr;
    @(negedge clk);
    rst = rst_v;
    inc = inc_v;
    #1;
    cur_addr = model_cnt % DEPTH;
    check("addr_next", 32'(addr_next), 32'((cur_addr + int'(inc_v)) % DEPTH));
    check("wrap", 32'(wrap), 32'(inc_v && cur_addr == DEPTH - 1));
    @(posedge clk);
    if (rst_v)      model_cnt = 0;
    else if (inc_v) model_cnt = (model_cnt + 1) % (2 * DEPTH);
    #1;
    check("addr",     32'(addr),     32'(model_cnt % DEPTH));
    check("lap",      32'(lap),      32'(model_cnt / DEPTH));
    check("ptr",      32'(ptr),      32'(model_cnt));
    check("ptr_gray", 32'(ptr_gray), 32'(exp_gray(model_cnt)));
  endtask

  initial begin
    rst = 1'b1;
    inc = 1'b1;

    // Reset held two cycles with inc high: inc is discarded.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("reset_ptr", 32'(ptr), 32'h0);

    // Three single increments: addr 1, 2, 3.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check("after_3_incs", 32'(addr), 32'd3);

    // Wrap: 16 increments from 0 end at ptr 0x10.
    step(1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1);
    check("ptr_after_lap", 32'(ptr), 32'h10);
    check("lap_after_wrap", 32'(lap), 32'd1);
`ifdef FIFO_ADDR_GRAY_EN
    check("gray_at_0x10", 32'(ptr_gray), 32'h18);
`endif

    // Full lap: another 16 increments return ptr to 0.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1);
    check("ptr_after_full", 32'(ptr), 32'h0);

    // Hold at addr 7 for five cycles.
    step(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    check("hold_addr", 32'(addr), 32'd7);

    // Reset mid-stream at addr 9, lap 1, then resume counting.
    step(1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 9; i++) step(1'b0, 1'b1);
    check("pre_reset_ptr", 32'(ptr), 32'h19);
    step(1'b1, 1'b1);
    check("mid_reset_ptr", 32'(ptr), 32'h0);
    step(1'b0, 1'b1);
    check("resume_addr", 32'(addr), 32'd1);

    // Randomized traffic: occasional reset, inc about half the time.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
